// File: rtl/gpgpu_pkg.sv
// Shared GPGPU types: collector geometry, per-unit state and entry layout.
// Reused by the operand collector and the arbiters that follow it.
package gpgpu_pkg;

  localparam int N_OC   = 4;
  localparam int OCID_W = $clog2(N_OC);
  localparam int ROW_W  = 3;
  localparam int WARP_W = 3;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OC_FREE  = 2'd0,
    OC_WAIT  = 2'd1,
    OC_READY = 2'd2
  } oc_state_t;

  // OC_FREE encodes as zero so an all-zero entry is a free, cleared unit
  typedef struct packed {
    logic [WARP_W-1:0] warp;
    logic [ROW_W-1:0]  row_a;
    logic [ROW_W-1:0]  row_b;
    logic              a_vld;
    logic              b_vld;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    oc_state_t         state;
  } oc_entry_t;

endpackage

// File: rtl/operand_collector_if.sv
// Operand collector bus: issue allocation, RF request, bank read return, CDB and dispatch.
// master = surrounding pipeline, slave = the collector.
interface operand_collector_if;
  import gpgpu_pkg::*;

  logic              alloc_valid;
  logic              alloc_ready;
  logic [WARP_W-1:0] alloc_warp;
  logic [ROW_W-1:0]  alloc_rowid_a;
  logic [ROW_W-1:0]  alloc_rowid_b;
  logic              alloc_2op;

  logic              req_en;
  logic              req_2op;
  logic [ROW_W-1:0]  req_rowid_a;
  logic [ROW_W-1:0]  req_rowid_b;
  logic [OCID_W-1:0] req_ocid;

  logic              rd_valid;
  logic [OCID_W-1:0] rd_ocid;
  logic [ROW_W-1:0]  rd_rowid;
  logic [DATA_W-1:0] rd_data;

  logic              cdb_wr;
  logic [ROW_W-1:0]  cdb_rowid;
  logic [DATA_W-1:0] cdb_data;

  logic              disp_valid;
  logic              disp_ready;
  logic [WARP_W-1:0] disp_warp;
  logic [OCID_W-1:0] disp_ocid;
  logic [DATA_W-1:0] disp_op_a;
  logic [DATA_W-1:0] disp_op_b;

  logic              err_stray;

  modport master (
    output alloc_valid, alloc_warp, alloc_rowid_a, alloc_rowid_b, alloc_2op,
    output rd_valid, rd_ocid, rd_rowid, rd_data,
    output cdb_wr, cdb_rowid, cdb_data,
    output disp_ready,
    input  alloc_ready,
    input  req_en, req_2op, req_rowid_a, req_rowid_b, req_ocid,
    input  disp_valid, disp_warp, disp_ocid, disp_op_a, disp_op_b,
    input  err_stray
  );

  modport slave (
    input  alloc_valid, alloc_warp, alloc_rowid_a, alloc_rowid_b, alloc_2op,
    input  rd_valid, rd_ocid, rd_rowid, rd_data,
    input  cdb_wr, cdb_rowid, cdb_data,
    input  disp_ready,
    output alloc_ready,
    output req_en, req_2op, req_rowid_a, req_rowid_b, req_ocid,
    output disp_valid, disp_warp, disp_ocid, disp_op_a, disp_op_b,
    output err_stray
  );

endinterface

// File: rtl/operand_collector_rr_arbiter.sv
// N-way round-robin arbiter, combinational grant starting at rr pointer.
// While a grant is stalled (!ack_i) the selection is frozen and rr does not move.
module oc_rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         ack_i,
  output logic         vld_o,
  output logic [W-1:0] sel_o
);

  logic [W-1:0]   rr_q;
  logic [W-1:0]   held_q;
  logic           hold_q;
  logic [W-1:0]   pick;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return W'(s);
  endfunction

  // rot[i] is the request sitting i positions after the rr pointer
  assign dbl = {req_i, req_i} >> rr_q;
  assign rot = dbl[N-1:0];

  always_comb begin
    pick = rr_q;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pick = wrap_add(rr_q, i);
    end
  end

  assign vld_o = |req_i;
  assign sel_o = hold_q ? held_q : pick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q   <= '0;
      held_q <= '0;
      hold_q <= 1'b0;
    end else if (vld_o) begin
      if (ack_i) begin
        rr_q   <= wrap_add(sel_o, 1);
        hold_q <= 1'b0;
      end else begin
        held_q <= sel_o;
        hold_q <= 1'b1;
      end
    end else begin
      hold_q <= 1'b0;
    end
  end

endmodule

// File: rtl/operand_collector.sv
// Operand collector: N_OC units gather RF read returns and dispatch round-robin; req 1 cycle after accept.
// Dispatch stalls on disp_ready with selection held; OC_BYPASS_EN adds CDB operand capture.
module operand_collector
  import gpgpu_pkg::*;
(
  input logic                clk,
  input logic                rst,
  operand_collector_if.slave oc
);

  oc_entry_t entry_q [N_OC];
  oc_entry_t entry_d [N_OC];

  logic [N_OC-1:0]   free_vec, ready_vec, rd_tgt, hit_a, hit_b, row_match;
  logic [OCID_W-1:0] alloc_idx, disp_sel;
  logic              accept, arb_vld, disp_fire, stray;

  logic              req_en_q, req_2op_q, err_stray_q;
  logic [ROW_W-1:0]  req_rowid_a_q, req_rowid_b_q;
  logic [OCID_W-1:0] req_ocid_q;

`ifdef OC_BYPASS_EN
  logic [N_OC-1:0]   cdb_a, cdb_b;
`else
  logic              unused_cdb;
  assign unused_cdb = ^{oc.cdb_wr, oc.cdb_rowid, oc.cdb_data};
`endif

  for (genvar g = 0; g < N_OC; g++) begin : g_unit
    assign free_vec[g]  = entry_q[g].state == OC_FREE;
    assign ready_vec[g] = entry_q[g].state == OC_READY;
    assign rd_tgt[g]    = oc.rd_valid && (oc.rd_ocid == OCID_W'(g)) && (entry_q[g].state == OC_WAIT);
    assign hit_a[g]     = rd_tgt[g] && (oc.rd_rowid == entry_q[g].row_a) && !entry_q[g].a_vld;
    assign hit_b[g]     = rd_tgt[g] && (oc.rd_rowid == entry_q[g].row_b) && !entry_q[g].b_vld;
`ifdef OC_BYPASS_EN
    assign cdb_a[g] = oc.cdb_wr && (entry_q[g].state == OC_WAIT) &&
                      (oc.cdb_rowid == entry_q[g].row_a) && !entry_q[g].a_vld;
    assign cdb_b[g] = oc.cdb_wr && (entry_q[g].state == OC_WAIT) &&
                      (oc.cdb_rowid == entry_q[g].row_b) && !entry_q[g].b_vld;
    // a return to an operand the CDB already filled is expected, not stray
    assign row_match[g] = rd_tgt[g] &&
                          ((oc.rd_rowid == entry_q[g].row_a) || (oc.rd_rowid == entry_q[g].row_b));
`else
    assign row_match[g] = hit_a[g] || hit_b[g];
`endif
  end

  assign stray = oc.rd_valid && !(|row_match);

  always_comb begin
    alloc_idx = '0;
    for (int i = N_OC - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = OCID_W'(i);
    end
  end

  assign oc.alloc_ready = |free_vec;
  assign accept         = oc.alloc_valid && (|free_vec);

  oc_rr_arbiter #(.N(N_OC), .W(OCID_W)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (ready_vec),
    .ack_i (oc.disp_ready),
    .vld_o (arb_vld),
    .sel_o (disp_sel)
  );

  assign disp_fire = arb_vld && oc.disp_ready;

  always_comb begin
    for (int i = 0; i < N_OC; i++) begin
      entry_d[i] = entry_q[i];
      case (entry_q[i].state)
        OC_FREE: begin
          if (accept && (alloc_idx == OCID_W'(i))) begin
            entry_d[i].warp  = oc.alloc_warp;
            entry_d[i].row_a = oc.alloc_rowid_a;
            entry_d[i].row_b = oc.alloc_2op ? oc.alloc_rowid_b : oc.alloc_rowid_a;
            entry_d[i].a_vld = 1'b0;
            entry_d[i].b_vld = !oc.alloc_2op;
            entry_d[i].op_a  = '0;
            entry_d[i].op_b  = '0;
            entry_d[i].state = OC_WAIT;
          end
        end
        OC_WAIT: begin
          if (hit_a[i]) begin
            entry_d[i].a_vld = 1'b1;
            entry_d[i].op_a  = oc.rd_data;
          end
          if (hit_b[i]) begin
            entry_d[i].b_vld = 1'b1;
            entry_d[i].op_b  = oc.rd_data;
          end
`ifdef OC_BYPASS_EN
          if (cdb_a[i]) begin
            entry_d[i].a_vld = 1'b1;
            entry_d[i].op_a  = oc.cdb_data;
          end
          if (cdb_b[i]) begin
            entry_d[i].b_vld = 1'b1;
            entry_d[i].op_b  = oc.cdb_data;
          end
`endif
          if (entry_d[i].a_vld && entry_d[i].b_vld) entry_d[i].state = OC_READY;
        end
        OC_READY: begin
          if (disp_fire && (disp_sel == OCID_W'(i))) entry_d[i] = '0;
        end
        default: entry_d[i] = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_OC; i++) entry_q[i] <= '0;
      req_en_q      <= 1'b0;
      req_2op_q     <= 1'b0;
      req_rowid_a_q <= '0;
      req_rowid_b_q <= '0;
      req_ocid_q    <= '0;
      err_stray_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N_OC; i++) entry_q[i] <= entry_d[i];
      req_en_q    <= accept;
      err_stray_q <= stray;
      if (accept) begin
        req_2op_q     <= oc.alloc_2op;
        req_rowid_a_q <= oc.alloc_rowid_a;
        req_rowid_b_q <= oc.alloc_2op ? oc.alloc_rowid_b : oc.alloc_rowid_a;
        req_ocid_q    <= alloc_idx;
      end
    end
  end

  assign oc.req_en      = req_en_q;
  assign oc.req_2op     = req_2op_q;
  assign oc.req_rowid_a = req_rowid_a_q;
  assign oc.req_rowid_b = req_rowid_b_q;
  assign oc.req_ocid    = req_ocid_q;
  assign oc.err_stray   = err_stray_q;

  assign oc.disp_valid = arb_vld;
  assign oc.disp_warp  = arb_vld ? entry_q[disp_sel].warp : '0;
  assign oc.disp_ocid  = arb_vld ? disp_sel : '0;
  assign oc.disp_op_a  = arb_vld ? entry_q[disp_sel].op_a : '0;
  assign oc.disp_op_b  = arb_vld ? entry_q[disp_sel].op_b : '0;

endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector: inputs change 1 time unit after posedge, outputs sampled on negedge.
module tb_operand_collector;
  import gpgpu_pkg::*;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  operand_collector_if bus();

  operand_collector dut (
    .clk (clk),
    .rst (rst),
    .oc  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.alloc_valid   = 1'b0;
    bus.alloc_warp    = '0;
    bus.alloc_rowid_a = '0;
    bus.alloc_rowid_b = '0;
    bus.alloc_2op     = 1'b0;
    bus.rd_valid      = 1'b0;
    bus.rd_ocid       = '0;
    bus.rd_rowid      = '0;
    bus.rd_data       = '0;
    bus.cdb_wr        = 1'b0;
    bus.cdb_rowid     = '0;
    bus.cdb_data      = '0;
    bus.disp_ready    = 1'b0;
  endtask

  task automatic alloc(input int warp, input int ra, input int rb, input logic two);
    bus.alloc_valid   = 1'b1;
    bus.alloc_warp    = WARP_W'(warp);
    bus.alloc_rowid_a = ROW_W'(ra);
    bus.alloc_rowid_b = ROW_W'(rb);
    bus.alloc_2op     = two;
  endtask

  task automatic rd(input int id, input int row, input logic [31:0] d);
    bus.rd_valid = 1'b1;
    bus.rd_ocid  = OCID_W'(id);
    bus.rd_rowid = ROW_W'(row);
    bus.rd_data  = d;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    step();
    sample();
    check("rst_alloc_ready", bus.alloc_ready, 1);
    check("rst_req_en", bus.req_en, 0);
    check("rst_req_ocid", bus.req_ocid, 0);
    check("rst_err_stray", bus.err_stray, 0);
    check("rst_disp_valid", bus.disp_valid, 0);
    check("rst_disp_op_a", bus.disp_op_a, 0);
    step();
    rst = 1'b1;

    // single 2-op alloc, rows 3/5, returns out of order
    alloc(5, 3, 5, 1'b1);
    sample();
    check("t1_alloc_ready", bus.alloc_ready, 1);
    step(); idle();
    sample();
    check("t1_req_en", bus.req_en, 1);
    check("t1_req_ocid", bus.req_ocid, 0);
    check("t1_req_row_a", bus.req_rowid_a, 3);
    check("t1_req_row_b", bus.req_rowid_b, 5);
    check("t1_req_2op", bus.req_2op, 1);
    step(); rd(0, 5, 32'hB);
    sample();
    check("t1_req_en_pulse", bus.req_en, 0);
    step(); rd(0, 3, 32'hA);
    sample();
    check("t1_disp_early", bus.disp_valid, 0);
    step(); idle();
    sample();
    check("t1_disp_valid", bus.disp_valid, 1);
    check("t1_op_a", bus.disp_op_a, 32'hA);
    check("t1_op_b", bus.disp_op_b, 32'hB);
    check("t1_warp", bus.disp_warp, 5);
    check("t1_ocid", bus.disp_ocid, 0);
    check("t1_no_stray", bus.err_stray, 0);
    step(); bus.disp_ready = 1'b1;
    sample();
    check("t1_disp_fire", bus.disp_valid, 1);
    step(); idle();
    sample();
    check("t1_disp_done", bus.disp_valid, 0);
    check("t1_disp_op_a_zero", bus.disp_op_a, 0);

    // four back-to-back allocs, then full
    for (int i = 0; i < 4; i++) begin
      step(); alloc(i, 1, 2, 1'b1);
      sample();
      check("t2_alloc_ready", bus.alloc_ready, 1);
      if (i > 0) check("t2_req_ocid", bus.req_ocid, i - 1);
    end
    step(); alloc(7, 1, 2, 1'b1);
    sample();
    check("t2_full", bus.alloc_ready, 0);
    check("t2_req_en_last", bus.req_en, 1);
    check("t2_req_ocid_last", bus.req_ocid, 3);
    step(); rd(2, 1, 32'h21);
    sample();
    check("t2_no_accept", bus.req_en, 0);
    check("t2_still_full", bus.alloc_ready, 0);
    step(); rd(2, 2, 32'h22);
    step(); bus.rd_valid = 1'b0; bus.disp_ready = 1'b1;
    sample();
    check("t2_disp_ocid", bus.disp_ocid, 2);
    check("t2_disp_op_a", bus.disp_op_a, 32'h21);
    check("t2_full_at_disp", bus.alloc_ready, 0);
    step(); bus.disp_ready = 1'b0;
    sample();
    check("t2_freed", bus.alloc_ready, 1);
    step(); bus.alloc_valid = 1'b0;
    sample();
    check("t2_realloc_req", bus.req_en, 1);
    check("t2_realloc_ocid", bus.req_ocid, 2);
    check("t2_full_again", bus.alloc_ready, 0);

    // round robin over units 0,1,2 with disp_ready toggling
    for (int g = 0; g < 3; g++) begin
      for (int r = 1; r <= 2; r++) begin
        step(); rd(g, r, 32'h10 * r + g);
      end
    end
    step(); idle();
    sample();
    check("t3_first_ocid", bus.disp_ocid, 0);
    check("t3_first_op_a", bus.disp_op_a, 32'h10);
    check("t3_first_op_b", bus.disp_op_b, 32'h20);
    step(); bus.disp_ready = 1'b0;
    sample();
    check("t3_hold_ocid", bus.disp_ocid, 0);
    check("t3_hold_op_a", bus.disp_op_a, 32'h10);
    step(); bus.disp_ready = 1'b1;
    sample();
    check("t3_fire0", bus.disp_ocid, 0);
    step(); bus.disp_ready = 1'b0;
    sample();
    check("t3_second_ocid", bus.disp_ocid, 1);
    check("t3_second_op_b", bus.disp_op_b, 32'h21);
    step(); bus.disp_ready = 1'b1;
    sample();
    check("t3_fire1", bus.disp_ocid, 1);
    step(); bus.disp_ready = 1'b0;
    sample();
    check("t3_third_ocid", bus.disp_ocid, 2);
    check("t3_third_warp", bus.disp_warp, 7);
    check("t3_third_op_a", bus.disp_op_a, 32'h12);
    step(); bus.disp_ready = 1'b1;
    sample();
    check("t3_fire2", bus.disp_ocid, 2);
    step(); bus.disp_ready = 1'b0;
    sample();
    check("t3_drained", bus.disp_valid, 0);

    // stray returns: FREE unit, then wrong row to WAIT unit 3
    step(); rd(0, 1, 32'h5);
    step(); rd(3, 6, 32'h5);
    sample();
    check("t4_stray_free", bus.err_stray, 1);
    step(); idle();
    sample();
    check("t4_stray_row", bus.err_stray, 1);
    check("t4_no_ready", bus.disp_valid, 0);
    step();
    sample();
    check("t4_stray_clear", bus.err_stray, 0);
    check("t4_free_kept", bus.alloc_ready, 1);
    check("t4_no_req", bus.req_en, 0);
    step(); rd(3, 1, 32'h31);
    step(); rd(3, 2, 32'h32);
    step(); idle(); bus.disp_ready = 1'b1;
    sample();
    check("t4_u3_ocid", bus.disp_ocid, 3);
    check("t4_u3_op_a", bus.disp_op_a, 32'h31);
    check("t4_u3_op_b", bus.disp_op_b, 32'h32);
    check("t4_u3_warp", bus.disp_warp, 3);
    check("t4_u3_no_stray", bus.err_stray, 0);

    // 1-op instruction, row 2
    step(); idle(); alloc(4, 2, 6, 1'b0);
    step(); idle();
    sample();
    check("t5_req_en", bus.req_en, 1);
    check("t5_req_2op", bus.req_2op, 0);
    check("t5_req_row_a", bus.req_rowid_a, 2);
    check("t5_req_row_b", bus.req_rowid_b, 2);
    check("t5_req_ocid", bus.req_ocid, 0);
    step(); rd(0, 2, 32'h55);
    step(); idle(); bus.disp_ready = 1'b1;
    sample();
    check("t5_disp_valid", bus.disp_valid, 1);
    check("t5_op_a", bus.disp_op_a, 32'h55);
    check("t5_op_b_zero", bus.disp_op_b, 0);
    check("t5_warp", bus.disp_warp, 4);

    // 2-op with both sources on row 4
    step(); idle(); alloc(6, 4, 4, 1'b1);
    step(); idle();
    step(); rd(0, 4, 32'h44);
    step(); idle(); bus.disp_ready = 1'b1;
    sample();
    check("t6_disp_valid", bus.disp_valid, 1);
    check("t6_op_a", bus.disp_op_a, 32'h44);
    check("t6_op_b", bus.disp_op_b, 32'h44);
    check("t6_no_stray", bus.err_stray, 0);

`ifdef OC_BYPASS_EN
    // CDB fills row 5 of unit 1; the later bank return for row 5 is dropped quietly
    step(); idle(); alloc(1, 1, 2, 1'b1);
    step(); alloc(2, 3, 5, 1'b1);
    step(); idle(); bus.cdb_wr = 1'b1; bus.cdb_rowid = 3'd5; bus.cdb_data = 32'h77;
    step(); idle(); rd(1, 5, 32'h99);
    step(); idle(); rd(1, 3, 32'h33);
    sample();
    check("t7_dropped_no_stray", bus.err_stray, 0);
    step(); idle(); bus.disp_ready = 1'b1;
    sample();
    check("t7_disp_ocid", bus.disp_ocid, 1);
    check("t7_op_a", bus.disp_op_a, 32'h33);
    check("t7_op_b_cdb", bus.disp_op_b, 32'h77);
    check("t7_no_stray", bus.err_stray, 0);
`endif

    // reset mid-operation drops in-flight units; late return is stray
    step(); idle(); alloc(0, 7, 7, 1'b1);
    step(); idle();
    step(); rst = 1'b0;
    sample();
    check("t8_rst_alloc_ready", bus.alloc_ready, 1);
    check("t8_rst_req_en", bus.req_en, 0);
    check("t8_rst_disp_valid", bus.disp_valid, 0);
    step(); rst = 1'b1; rd(0, 7, 32'h1);
    step(); idle();
    sample();
    check("t8_late_stray", bus.err_stray, 1);
    check("t8_no_ready", bus.disp_valid, 0);
    step();
    sample();
    check("t8_stray_clear", bus.err_stray, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_collector.md
Name: operand_collector

Overview:
- Sits directly upstream of the register-file controller's request FIFO and consumes the bank read data it produces.
- Holds N_OC collector units. Each accepts one issued warp instruction and raises a read request toward the RF controller (ocid, row a, row b, 2-op flag).
- Captures the returned operand data tagged by ocid and row. Dispatches complete operand sets to the execute stage through a round-robin arbiter.

Parameters:
- N_OC, 4, number of collector units (ocid width = clog2(N_OC)).
- OCID_W, 2, collector id width; must equal clog2(N_OC).
- ROW_W, 3, register row address width.
- WARP_W, 3, warp id width.
- DATA_W, 32, operand data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  issue stage offers an instruction.
- alloc_ready  out  1  at least one collector unit is FREE.
- alloc_warp  in  WARP_W  warp id.
- alloc_rowid_a  in  ROW_W  source row a.
- alloc_rowid_b  in  ROW_W  source row b.
- alloc_2op  in  1  1 = two sources; 0 = source a only.
- req_en  out  1  one-cycle request pulse to the RF controller.
- req_2op  out  1  request carries two operands.
- req_rowid_a  out  ROW_W  row a of the request.
- req_rowid_b  out  ROW_W  row b of the request.
- req_ocid  out  OCID_W  collector id of the request.
- rd_valid  in  1  bank read data valid.
- rd_ocid  in  OCID_W  tag of the returned data.
- rd_rowid  in  ROW_W  row of the returned data.
- rd_data  in  DATA_W  returned operand.
- cdb_wr  in  1  CDB writeback strobe (used only with OC_BYPASS_EN).
- cdb_rowid  in  ROW_W  CDB write row.
- cdb_data  in  DATA_W  CDB write data.
- disp_valid  out  1  a complete operand set is available.
- disp_ready  in  1  execute stage accepts.
- disp_warp  out  WARP_W  warp of the dispatched set.
- disp_ocid  out  OCID_W  source collector id.
- disp_op_a  out  DATA_W  operand a.
- disp_op_b  out  DATA_W  operand b; 0 when the instruction is 1-op.
- err_stray  out  1  one-cycle pulse on an unmatched read return.

Behaviour:
- Reset (asynchronous, rst=0):
  - all units FREE; valid bits and data cleared; rr pointer = 0.
  - req_en, req_*, err_stray = 0; disp_valid = 0; disp_* = 0.
- Per-unit state machine: FREE -> WAIT on accept; WAIT -> READY when all needed operand-valid bits are set; READY -> FREE on dispatch handshake.
- alloc_ready:
  - = OR of FREE over all units, from registered state only.
  - A unit freed this cycle is allocatable next cycle, not in the same cycle.
- Accept (alloc_valid && alloc_ready):
  - the lowest-index FREE unit latches warp, rows and 2op.
  - a_vld = 0; b_vld = !alloc_2op.
- Request outputs:
  - registered; req_en pulses exactly 1 cycle after accept, with req_ocid = the allocated index.
  - when !alloc_2op, req_rowid_b = alloc_rowid_a and req_2op = 0.
- Read capture (rd_valid with unit rd_ocid in WAIT):
  - if rd_rowid == row_a && !a_vld, capture into a.
  - independently, if rd_rowid == row_b && !b_vld, capture into b.
  - when row_a == row_b, a single return fills both.
- Stray return: rd_valid to a FREE or READY unit, or with no row match, is ignored and err_stray pulses 1 cycle later.
- WAIT -> READY takes effect the cycle after the final capture; disp_valid can first assert in that cycle.
- Dispatch:
  - disp_valid = any READY; disp_* are combinational muxes of the selected unit.
  - selection is round-robin starting at the rr pointer.
  - on disp_valid && disp_ready, the selected unit goes FREE and rr = (sel+1) mod N_OC.
  - while disp_ready = 0, the selection is held stable; rr does not move and outputs do not change.
- Simultaneous events:
  - accept, capture and dispatch on distinct units in one cycle are all honoured.
  - dispatch and capture cannot hit the same unit (READY vs WAIT).
- rst asserted mid-operation: in-flight units are dropped; late returns after reset release count as stray.

Optional Feature:
- Macro: OC_BYPASS_EN.
- Defined:
  - a cdb_wr whose cdb_rowid matches row_a/row_b of a WAIT unit with the corresponding vld = 0 captures cdb_data and sets vld.
  - if rd and cdb hit the same operand in the same cycle, cdb has priority.
  - a later rd return to an already-valid operand is silently dropped and does not raise err_stray.
- Undefined: cdb_* ports exist but are ignored; behaviour is exactly as above.

Decomposition:
- Shared package gpgpu_pkg:
  - ROW_W, WARP_W, DATA_W, OCID_W, N_OC.
  - oc_state_t enum (FREE, WAIT, READY).
  - oc_entry_t struct (warp, row_a, row_b, a_vld, b_vld, op_a, op_b, state).
- Sub-module oc_rr_arbiter: N-way round-robin with hold-while-stalled, reused by later arbiters.

Test Plan:
- Single 2-op alloc, rows 3/5:
  - req_en with ocid 0 one cycle after accept.
  - returns row5=0xB, then row3=0xA.
  - disp_valid next cycle with op_a=0xA, op_b=0xB, warp echoed.
- Four back-to-back allocs: ocid 0..3 assigned; alloc_ready = 0 on the fifth until one unit dispatches, then 1 the cycle after.
- 1-op and same-row cases:
  - alloc_2op = 0, row 2: one return gives op_b = 0.
  - 2-op with rows 4/4: a single return fills both operands.
- Round-robin: units 0, 1, 2 all READY with disp_ready toggling 0/1. Dispatch order is 0, 1, 2; outputs hold steady while disp_ready = 0.
- Stray return: rd_valid to a FREE ocid, and a wrong row to a WAIT unit. Each gives an err_stray pulse; no state change.
- OC_BYPASS_EN: cdb_wr row 5 = 0x77 while unit 1 waits on row 5. Operand captured; a later rd for row 5 is dropped with no err_stray.
